// File: rtl/max7219_frame_sched.sv
// max7219_frame_sched: command scheduler feeding a MAX7219 serial driver.
// Runs the MAX7219 init sequence after reset, then writes 8-digit frames
// (HH-MM-SS time or a PPS checker pattern) on a periodic tick or when a new
// 6-byte time frame has been captured. One register write at a time is
// handed to the driver.
//
// Handshake: a command transfers on any sys_clk edge where cmd_valid and
// cmd_ready are both high; cmd_addr/cmd_data hold stable while cmd_valid is
// high and not yet accepted, and the next command of a sequence is presented
// on the edge of the accept, so a ready driver sees no gap cycle.
//
// Optional feature macro: MAX7219_REINIT_EN -- periodic re-init every
// REINIT_FRAMES frames. Without it, INIT runs only after reset.
module max7219_frame_sched #(
  parameter int          REFRESH_CYC   = 5000000,
  parameter int          GAP_CYC       = 50000,
  parameter logic [7:0]  DECODE        = 8'hFF,
  parameter logic [7:0]  SCAN_LIMIT    = 8'h07,
  parameter logic [3:0]  INTEN_RST     = 4'h8,
  parameter int          REINIT_FRAMES = 64
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic [7:0] pi_data,
  input  logic       flag,
  input  logic       pps,
  input  logic       inten_req,
  input  logic [3:0] inten_val,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       init_done,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CFG, ST_FRAME} state_t;

  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t      state;
  logic [2:0]  step;
  logic [RW-1:0] ref_cnt;
  logic        tick;
  logic [GW-1:0] gap_cnt;
  logic [2:0]  byte_cnt;
  logic [2:0]  eff_cnt;
  logic        gap_timeout;
  logic        commit;
  logic [39:0] shadow;
  logic [47:0] pending;
  logic        dirty;
  logic [47:0] snap_buf;
  logic        snap_pps;
  logic        inten_pend;
  logic [3:0]  inten_lat;
  logic        reinit_pend;
  logic        in_idle;
  logic        reinit_start;
  logic        cfg_start;
  logic        frame_start;

  assign dbg_state = state;

  // Init table entry i: {address, data}
  function automatic logic [15:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return {8'h0C, 8'h00};
      3'd1:    return {8'h09, DECODE};
      3'd2:    return {8'h0A, 4'h0, INTEN_RST};
      3'd3:    return {8'h0B, SCAN_LIMIT};
      3'd4:    return {8'h0F, 8'h00};
      default: return {8'h0C, 8'h01};
    endcase
  endfunction

  // Digit k (0 = digit register 0x01) of a frame; t holds b0 in [47:40] .. b5 in [7:0]
  function automatic logic [7:0] digit(input logic [47:0] t, input logic pat,
                                       input logic [2:0] k);
    if (pat) return k[0] ? 8'h55 : 8'hAA;
    case (k)
      3'd0:    return t[7:0];
      3'd1:    return t[15:8];
      3'd2:    return 8'h0A;
      3'd3:    return t[23:16];
      3'd4:    return t[31:24];
      3'd5:    return 8'h0A;
      3'd6:    return t[39:32];
      default: return t[47:40];
    endcase
  endfunction

  // IDLE arbitration: reinit > intensity change > (tick or dirty)
  always_comb begin
    in_idle      = (state == ST_IDLE);
    reinit_start = in_idle && reinit_pend;
    cfg_start    = in_idle && !reinit_pend && inten_pend;
    frame_start  = in_idle && !reinit_pend && !inten_pend && (tick || dirty);
  end

  // A flag on the cycle the gap expires starts a fresh frame at byte 0
  always_comb begin
    gap_timeout = (gap_cnt == GW'(GAP_CYC));
    eff_cnt     = gap_timeout ? 3'd0 : byte_cnt;
    commit      = flag && (eff_cnt == 3'd5);
  end

  // Free-running refresh counter; a wrap sets tick, frame start clears it
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      ref_cnt <= '0;
      tick    <= 1'b0;
    end else if (ref_cnt == RW'(REFRESH_CYC - 1)) begin
      ref_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
      if (frame_start) tick <= 1'b0;
    end
  end

  // Time byte capture with inter-byte gap timeout and 6-byte commit
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      gap_cnt  <= '0;
      byte_cnt <= 3'd0;
      shadow   <= '0;
      pending  <= '0;
    end else if (flag) begin
      gap_cnt <= '0;
      shadow  <= {shadow[31:0], pi_data};
      if (eff_cnt == 3'd5) begin
        pending  <= {shadow, pi_data};
        byte_cnt <= 3'd0;
      end else begin
        byte_cnt <= eff_cnt + 3'd1;
      end
    end else if (byte_cnt == 3'd0) begin
      gap_cnt <= '0;
    end else if (gap_timeout) begin
      byte_cnt <= 3'd0;
      gap_cnt  <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Dirty flag: a commit wins over a simultaneous frame start
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst)            dirty <= 1'b0;
    else if (commit)      dirty <= 1'b1;
    else if (frame_start) dirty <= 1'b0;
  end

  // Intensity request latch; the last value before service wins
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      inten_pend <= 1'b0;
      inten_lat  <= 4'h0;
    end else if (inten_req) begin
      inten_pend <= 1'b1;
      inten_lat  <= inten_val;
    end else if (cfg_start) begin
      inten_pend <= 1'b0;
    end
  end

`ifdef MAX7219_REINIT_EN
  localparam int FW = (REINIT_FRAMES > 1) ? $clog2(REINIT_FRAMES) : 1;
  logic [FW-1:0] frm_cnt;
  logic          frame_end;

  assign frame_end = (state == ST_FRAME) && cmd_valid && cmd_ready && (step == 3'd7);

  // Count completed frames and request a re-init every REINIT_FRAMES frames
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      frm_cnt     <= '0;
      reinit_pend <= 1'b0;
    end else begin
      if (frame_end) begin
        if (frm_cnt == FW'(REINIT_FRAMES - 1)) begin
          frm_cnt     <= '0;
          reinit_pend <= 1'b1;
        end else begin
          frm_cnt <= frm_cnt + FW'(1);
        end
      end
      if (reinit_start) reinit_pend <= 1'b0;
    end
  end
`else
  assign reinit_pend = 1'b0;
`endif

  // Main sequencer: INIT table, intensity write, frame writes
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      state      <= ST_INIT;
      step       <= 3'd0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= 8'h00;
      cmd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      snap_buf   <= '0;
      snap_pps   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (!cmd_valid) begin
            cmd_valid            <= 1'b1;
            {cmd_addr, cmd_data} <= init_cmd(step);
          end else if (cmd_ready) begin
            if (step == 3'd5) begin
              cmd_valid <= 1'b0;
              init_done <= 1'b1;
              step      <= 3'd0;
              state     <= ST_IDLE;
            end else begin
              step                 <= step + 3'd1;
              {cmd_addr, cmd_data} <= init_cmd(step + 3'd1);
            end
          end
        end
        ST_IDLE: begin
          if (reinit_start) begin
            state                <= ST_INIT;
            init_done            <= 1'b0;
            step                 <= 3'd0;
            cmd_valid            <= 1'b1;
            {cmd_addr, cmd_data} <= init_cmd(3'd0);
          end else if (cfg_start) begin
            state     <= ST_CFG;
            cmd_valid <= 1'b1;
            cmd_addr  <= 8'h0A;
            cmd_data  <= {4'h0, inten_lat};
          end else if (frame_start) begin
            state     <= ST_FRAME;
            step      <= 3'd0;
            snap_buf  <= pending;
            snap_pps  <= pps;
            cmd_valid <= 1'b1;
            cmd_addr  <= 8'h01;
            cmd_data  <= digit(pending, pps, 3'd0);
          end
        end
        ST_CFG: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (cmd_ready) begin
            if (step == 3'd7) begin
              cmd_valid  <= 1'b0;
              frame_done <= 1'b1;
              step       <= 3'd0;
              state      <= ST_IDLE;
            end else begin
              step     <= step + 3'd1;
              cmd_addr <= {5'b0, step} + 8'd2;
              cmd_data <= digit(snap_buf, snap_pps, step + 3'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_frame_sched.sv
// Testbench for max7219_frame_sched: directed time frames, gap handling,
// stall behaviour, intensity change, PPS pattern, periodic tick, mid-command reset.
module tb_max7219_frame_sched;

  localparam int REFRESH_CYC   = 2000;
  localparam int GAP_CYC       = 20;
  localparam int REINIT_FRAMES = 2;

  logic       sys_clk = 1'b0;
  logic       _rst;
  logic [7:0] pi_data;
  logic       flag;
  logic       pps;
  logic       inten_req;
  logic [3:0] inten_val;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       init_done;
  logic       frame_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int frames_pushed = 0;
  logic [15:0] exp_q[$];

  max7219_frame_sched #(
    .REFRESH_CYC  (REFRESH_CYC),
    .GAP_CYC      (GAP_CYC),
    .DECODE       (8'hFF),
    .SCAN_LIMIT   (8'h07),
    .INTEN_RST    (4'h8),
    .REINIT_FRAMES(REINIT_FRAMES)
  ) dut (
    .sys_clk   (sys_clk),
    ._rst      (_rst),
    .pi_data   (pi_data),
    .flag      (flag),
    .pps       (pps),
    .inten_req (inten_req),
    .inten_val (inten_val),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .init_done (init_done),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected-response builders
  task automatic push_init();
    exp_q.push_back(16'h0C00);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic frame_tail();
    frames_pushed++;
`ifdef MAX7219_REINIT_EN
    if (frames_pushed % REINIT_FRAMES == 0) push_init();
`endif
  endtask

  task automatic push_time(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back({8'h01, b5});
    exp_q.push_back({8'h02, b4});
    exp_q.push_back({8'h03, 8'h0A});
    exp_q.push_back({8'h04, b3});
    exp_q.push_back({8'h05, b2});
    exp_q.push_back({8'h06, 8'h0A});
    exp_q.push_back({8'h07, b1});
    exp_q.push_back({8'h08, b0});
    frame_tail();
  endtask

  task automatic push_pattern();
    for (int k = 1; k <= 8; k++)
      exp_q.push_back({8'(k), (k % 2 == 1) ? 8'hAA : 8'h55});
    frame_tail();
  endtask

  // Driver tasks (called at posedge+1)
  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    flag    = 1'b1;
    pi_data = v;
    @(posedge sys_clk);
    #1;
    flag = 1'b0;
  endtask

  task automatic send_six(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic wait_addr(input string name, input logic [7:0] a, input int budget);
    int n = 0;
    while (!(cmd_valid && cmd_addr == a) && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!(cmd_valid && cmd_addr == a)) begin
      checks++;
      errors++;
      $display("FAIL %s_wait actual=%0h required=%0h", name, cmd_addr, a);
    end
  endtask

  // Scoreboard monitor: pops on each accepted command, checks hold stability
  // and the frame_done / init_done pulses that follow specific accepts
  logic        hold_v;
  logic [15:0] hold_cmd;
  logic        exp_fd;
  logic        exp_id;
  logic [15:0] e;

  always @(negedge sys_clk) begin
    if (!_rst) begin
      hold_v = 1'b0;
      exp_fd = 1'b0;
      exp_id = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", {15'd0, cmd_valid}, 16'd1);
        check("hold_cmd", {cmd_addr, cmd_data}, hold_cmd);
      end
      if (exp_fd || frame_done) check("frame_done", {15'd0, frame_done}, {15'd0, exp_fd});
      if (exp_id) check("init_done", {15'd0, init_done}, 16'd1);
      exp_fd = 1'b0;
      exp_id = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd actual=%0h required=none", {cmd_addr, cmd_data});
        end else begin
          e = exp_q.pop_front();
          check("cmd", {cmd_addr, cmd_data}, e);
          if (e == 16'h0C01) exp_id = 1'b1;
          if (e[15:8] == 8'h08) exp_fd = 1'b1;
        end
      end
      hold_v   = cmd_valid && !cmd_ready;
      hold_cmd = {cmd_addr, cmd_data};
    end
  end

  // Stimulus
  initial begin
    _rst      = 1'b0;
    pi_data   = 8'h00;
    flag      = 1'b0;
    pps       = 1'b0;
    inten_req = 1'b0;
    inten_val = 4'h0;
    cmd_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_valid", {15'd0, cmd_valid}, 16'd0);
    check("rst_addr", {8'd0, cmd_addr}, 16'd0);
    check("rst_data", {8'd0, cmd_data}, 16'd0);
    check("rst_init_done", {15'd0, init_done}, 16'd0);
    check("rst_frame_done", {15'd0, frame_done}, 16'd0);

    // Init sequence, first command on the first edge after release
    push_init();
    @(posedge sys_clk); #1;
    _rst = 1'b1;
    @(posedge sys_clk); #1;
    check("first_valid", {15'd0, cmd_valid}, 16'd1);
    check("first_cmd", {cmd_addr, cmd_data}, 16'h0C00);
    wait_drain("init", 50);
    check("init_done_hi", {15'd0, init_done}, 16'd1);

    // Basic time frame
    push_time(8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03);
    send_six(8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03);
    wait_drain("frame1", 100);

    // Partial frame discarded after GAP_CYC idle cycles
    send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
    idle(GAP_CYC);
    push_time(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h23);
    send_six(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h23);
    wait_drain("gap", 100);

    // Short pause below the gap keeps the partial frame
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(5);
    push_time(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    wait_drain("short_gap", 100);

    // Stall mid-frame with a commit during the stall
    push_time(8'h21, 8'h43, 8'h65, 8'h07, 8'h08, 8'h09);
    send_six(8'h21, 8'h43, 8'h65, 8'h07, 8'h08, 8'h09);
    wait_addr("stall", 8'h03, 50);
    cmd_ready = 1'b0;
    send_six(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h59);
    push_time(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h59);
    idle(4);
    cmd_ready = 1'b1;
    wait_drain("stall", 150);

    // Two intensity requests during a frame -> one write with the last value
    push_time(8'h08, 8'h15, 8'h42, 8'h19, 8'h27, 8'h36);
    send_six(8'h08, 8'h15, 8'h42, 8'h19, 8'h27, 8'h36);
    wait_addr("inten", 8'h02, 50);
    inten_req = 1'b1;
    inten_val = 4'h3;
    @(posedge sys_clk); #1;
    inten_val = 4'hC;
    @(posedge sys_clk); #1;
    inten_req = 1'b0;
    inten_val = 4'h0;
    exp_q.push_back(16'h0A0C);
    wait_drain("inten", 150);

    // Periodic tick with pps=1 -> pattern; pps drop mid-frame ignored
    pps = 1'b1;
    push_pattern();
    wait_addr("pattern", 8'h03, 2500);
    pps = 1'b0;
    wait_drain("pattern", 100);

    // Next tick with pps=0 repeats the last committed time
    push_time(8'h08, 8'h15, 8'h42, 8'h19, 8'h27, 8'h36);
    wait_drain("tick2", 2500);

    // Reset mid-frame drops cmd_valid at once and restarts INIT
    push_time(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    send_six(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    wait_addr("midrst", 8'h03, 50);
    _rst = 1'b0;
    #1;
    check("midrst_valid", {15'd0, cmd_valid}, 16'd0);
    check("midrst_init_done", {15'd0, init_done}, 16'd0);
    exp_q.delete();
    frames_pushed = 0;
    push_init();
    @(posedge sys_clk); #1;
    _rst = 1'b1;
    wait_drain("reinit_after_rst", 50);
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
